load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store engine between the CPU control unit and the SoC data memory.
- Accepts one load/store request from the control unit and converts it to a word-aligned memory transaction with byte strobes.
- Extracts bytes/halfwords from read data and sign- or zero-extends them (LB/LBU/LH/LHU/LW); replicates store data (SB/SH/SW).
- Reports completion or fault back to the control unit. Memory may take a variable number of cycles.

Parameters:
- ACK_TIMEOUT, 16: maximum ACCESS cycles waiting for mem_ack before faulting; valid range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_valid  in  1  control unit presents a request.
- cpu_ready  out  1  unit can accept a request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_funct3  in  3  RV32I load/store funct3.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data (rs2).
- cpu_rdata  out  32  extended load result; held until the next successful load.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_fault  out  1  valid with cpu_done; 1 = misaligned, illegal funct3 or timeout.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  write enable.
- mem_addr  out  32  {cpu_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte-lane strobes; 0 for loads.
- mem_ack  in  1  memory completed; mem_rdata valid in the same cycle.
- mem_rdata  in  32  word read data.

Behaviour:
- Reset (reset=0, async): state IDLE.
  - Outputs: cpu_ready=1, cpu_done=0, cpu_fault=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Timeout counter = 0.
- States and transitions:
  - IDLE: cpu_ready=1. Accept on the rising edge with cpu_valid=1, latching we, funct3, addr and wdata.
    - Legal and aligned request: go to ACCESS.
    - Otherwise: go to RESP with fault=1; no memory access is issued.
  - ACCESS: cpu_ready=0, mem_req=1, other mem_* driven from latched fields, counter increments each cycle.
    - mem_ack=1 at the edge: capture the load result and go to RESP with fault=0.
    - Counter reaches ACK_TIMEOUT without ack: go to RESP with fault=1; cpu_rdata is unchanged.
  - RESP: cpu_done=1 and cpu_fault=fault for exactly one cycle; then IDLE. cpu_ready=0 in RESP.
- Latency:
  - Ack in the first ACCESS cycle gives cpu_done in the 2nd cycle after the accept edge.
  - Each wait cycle adds 1.
  - A faulting request gives cpu_done in the 1st cycle after accept.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal and faults.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- Load extraction: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Store encoding:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111, wdata unchanged.
- cpu_valid is ignored outside IDLE; the control unit holds it until it sees cpu_ready.
- mem_ack outside ACCESS is ignored.
- Reset mid-ACCESS: mem_req drops immediately (async) and no cpu_done is produced. A late ack after reset release is ignored.
- Stores never modify cpu_rdata.

Test Plan:
- LBU/LB, ack in 1 cycle: mem_rdata=32'h80FF7F01 at addr 0x103.
  - LBU → cpu_rdata=32'h00000080.
  - LB same address → 32'hFFFFFF80.
  - cpu_done in the 2nd cycle after accept.
- LH/LHU at addr 0x202, mem_rdata=32'h8001_1234: LH → 32'hFFFF8001; LHU → 32'h00008001.
- SB at addr 0x005, wdata=32'h000000AB: mem_addr=0x004, mem_wstrb=4'b0010, mem_wdata=32'hABABABAB, mem_we=1.
  - cpu_rdata unchanged from the previous load.
- LW at addr 0x006: no mem_req; cpu_done=1, cpu_fault=1 the cycle after accept.
  - funct3=3'b011 behaves the same.
- mem_ack never asserted, ACK_TIMEOUT=16: mem_req high for exactly 16 cycles, then cpu_done=1, cpu_fault=1; cpu_ready returns the following cycle.
- reset low for 1 cycle during ACCESS (ack delayed 5 cycles): mem_req falls asynchronously, no cpu_done, cpu_ready=1 after release, stray ack ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: turns one control-unit request into a word-aligned
// memory transaction with byte strobes, extends load data and reports done/fault.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        req_legal;
    logic        req_aligned;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [3:0]  store_strb;
    logic [31:0] store_data;

    // Decode the incoming request: funct3 legality depends on load vs store,
    // alignment depends on access size (funct3[1:0]).
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        case (cpu_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~cpu_we;
            default:                req_legal = 1'b0;
        endcase
        case (cpu_funct3[1:0])
            2'b01:   req_aligned = ~cpu_addr[0];
            2'b10:   req_aligned = (cpu_addr[1:0] == 2'b00);
            default: req_aligned = 1'b1;
        endcase
    end

    always_comb begin
        load_byte  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        load_half  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_value = mem_rdata;
        case (funct3_q)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b100:  load_value = {24'h000000, load_byte};
            3'b101:  load_value = {16'h0000, load_half};
            default: load_value = mem_rdata;
        endcase
    end

    always_comb begin
        store_strb = 4'b1111;
        store_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_strb = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_strb = 4'b0011 << addr_q[1:0];
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    // Memory outputs are combinational on state so an async reset drops mem_req at once.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        cpu_ready = 1'b0;
        cpu_done  = 1'b0;
        cpu_fault = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
                    we_d     = cpu_we;
                    funct3_d = cpu_funct3;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    cnt_d    = 8'd0;
                    if (req_legal && req_aligned) begin
                        fault_d = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    mem_wstrb = store_strb;
                    mem_wdata = store_data;
                end
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = load_value;
                    end
                    fault_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cpu_done  = 1'b1;
                cpu_fault = fault_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a monitor and a memory responder pop and compare independently.
module tb_load_store_unit;

    typedef struct {
        bit          fault;
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          len;
    } mem_t;

    logic        clk;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    resp_t       resp_q[$];
    mem_t        mem_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle_cnt = 0;
    int          accept_cycle = 0;
    int          done_count = 0;
    int          ack_delay = 0;
    logic [31:0] mem_rdata_next = 32'h0;
    bit          stray_ack = 1'b0;

    load_store_unit #(.ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_funct3 (cpu_funct3),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_fault  (cpu_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Response monitor: every cpu_done must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_done === 1'b1) begin
                resp_t r;
                done_count++;
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: actual=1 expected=0");
                end else begin
                    r = resp_q.pop_front();
                    checkOutput("fault", 32'(cpu_fault), 32'(r.fault));
                    checkOutput("rdata", cpu_rdata, r.rdata);
                    checkOutput("latency", 32'(cycle_cnt - accept_cycle), 32'(r.lat));
                    checkOutput("ready_in_resp", 32'(cpu_ready), 32'd0);
                end
            end
        end
    end

    // Memory responder: checks the transaction on its first cycle, acks after ack_delay
    // wait cycles and checks how long mem_req stayed high.
    initial begin
        bit   active;
        bit   have_exp;
        int   k;
        mem_t cur;
        active   = 1'b0;
        have_exp = 1'b0;
        k        = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    k      = 0;
                    if (mem_q.size() == 0) begin
                        have_exp = 1'b0;
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_mem_req: actual=1 expected=0");
                    end else begin
                        have_exp = 1'b1;
                        cur = mem_q.pop_front();
                        checkOutput("mem_addr", mem_addr, cur.addr);
                        checkOutput("mem_we", 32'(mem_we), 32'(cur.we));
                        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
                        checkOutput("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    k++;
                end
                mem_ack   = stray_ack | (k == ack_delay);
                mem_rdata = mem_rdata_next;
            end else begin
                if (active && have_exp && cur.len > 0) begin
                    checkOutput("req_cycles", 32'(k + 1), 32'(cur.len));
                end
                active  = 1'b0;
                mem_ack = stray_ack;
            end
        end
    end

    task automatic applyStimulus(
        input bit          we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          delay,
        input logic [31:0] rd,
        input bit          exp_fault,
        input logic [31:0] exp_rdata,
        input int          exp_lat,
        input bit          exp_mem,
        input logic [31:0] exp_addr,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wdata
    );
        mem_t  m;
        resp_t r;
        int    waits;
        ack_delay      = delay;
        mem_rdata_next = rd;
        if (exp_mem) begin
            m.addr  = exp_addr;
            m.we    = we;
            m.strb  = exp_strb;
            m.wdata = exp_wdata;
            m.len   = exp_lat;
            mem_q.push_back(m);
        end
        r.fault = exp_fault;
        r.rdata = exp_rdata;
        r.lat   = exp_lat;
        resp_q.push_back(r);
        waits = 0;
        while (cpu_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("ready_before_req", 32'(cpu_ready), 32'd1);
        @(negedge clk);
        cpu_valid  = 1'b1;
        cpu_we     = we;
        cpu_funct3 = f3;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        @(posedge clk);
        #1;
        accept_cycle = cycle_cnt;
        cpu_valid    = 1'b0;
        waits = 0;
        while (resp_q.size() != 0 && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (resp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: actual=no_done expected=done");
            resp_q.delete();
        end
        @(negedge clk);
        checkOutput("ready_after_resp", 32'(cpu_ready), 32'd1);
    endtask

    initial begin
        int done_before;
        reset      = 1'b0;
        cpu_valid  = 1'b0;
        cpu_we     = 1'b0;
        cpu_funct3 = 3'b000;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        #12;
        checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        checkOutput("rst_cpu_done", 32'(cpu_done), 32'd0);
        checkOutput("rst_cpu_fault", 32'(cpu_fault), 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // we, f3, addr, wdata, delay, mem_rdata, fault, rdata, latency, mem?, mem_addr, strb, mem_wdata
        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF7F01, 1'b0, 32'h00000080, 1, 1'b1, 32'h100, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF7F01, 1'b0, 32'hFFFFFF80, 1, 1'b1, 32'h100, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h80011234, 1'b0, 32'hFFFF8001, 3, 1'b1, 32'h200, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h202, 32'h0, 1, 32'h80011234, 1'b0, 32'h00008001, 2, 1'b1, 32'h200, 4'b0000, 32'h0);
        applyStimulus(1'b1, 3'b000, 32'h005, 32'h000000AB, 0, 32'h55555555, 1'b0, 32'h00008001, 1, 1'b1, 32'h004, 4'b0010, 32'hABABABAB);
        applyStimulus(1'b1, 3'b001, 32'h00A, 32'h1234CAFE, 1, 32'h55555555, 1'b0, 32'h00008001, 2, 1'b1, 32'h008, 4'b1100, 32'hCAFECAFE);
        applyStimulus(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, 32'h55555555, 1'b0, 32'h00008001, 1, 1'b1, 32'h010, 4'b1111, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b010, 32'h006, 32'h0, 0, 32'h0, 1'b1, 32'h00008001, 0, 1'b0, 32'h0, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h000, 32'h0, 0, 32'h0, 1'b1, 32'h00008001, 0, 1'b0, 32'h0, 4'b0000, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h020, 32'h11223344, 0, 32'h0, 1'b1, 32'h00008001, 0, 1'b0, 32'h0, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h201, 32'h0, 0, 32'h0, 1'b1, 32'h00008001, 0, 1'b0, 32'h0, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 3, 32'h12345678, 1'b0, 32'h12345678, 4, 1'b1, 32'h300, 4'b0000, 32'h0);
        // No ack at all: 16 request cycles, then a fault with the old load data kept.
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 1000, 32'hFFFFFFFF, 1'b1, 32'h12345678, 16, 1'b1, 32'h400, 4'b0000, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h001, 32'h0, 0, 32'h00007F00, 1'b0, 32'h0000007F, 1, 1'b1, 32'h000, 4'b0000, 32'h0);

        // Reset in the middle of an access whose ack would come after 5 wait cycles.
        ack_delay      = 5;
        mem_rdata_next = 32'hA5A5A5A5;
        begin
            mem_t m;
            m.addr  = 32'h500;
            m.we    = 1'b0;
            m.strb  = 4'b0000;
            m.wdata = 32'h0;
            m.len   = 0;
            mem_q.push_back(m);
        end
        @(negedge clk);
        cpu_valid  = 1'b1;
        cpu_we     = 1'b0;
        cpu_funct3 = 3'b010;
        cpu_addr   = 32'h500;
        cpu_wdata  = 32'h0;
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mem_req_before_reset", 32'(mem_req), 32'd1);
        done_before = done_count;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mem_req_async_drop", 32'(mem_req), 32'd0);
        checkOutput("ready_in_reset", 32'(cpu_ready), 32'd1);
        @(posedge clk);
        #3;
        reset     = 1'b1;
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no_done_after_reset", 32'(done_count), 32'(done_before));
        checkOutput("mem_req_after_stray_ack", 32'(mem_req), 32'd0);
        checkOutput("ready_after_reset", 32'(cpu_ready), 32'd1);
        checkOutput("rdata_after_reset", cpu_rdata, 32'h0);

        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF7F01, 1'b0, 32'h00000080, 1, 1'b1, 32'h100, 4'b0000, 32'h0);

        checkOutput("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
